// File: rtl/svc_rv_uart_pkg.sv
// rtl/svc_rv_uart_pkg.sv - register map, status bit positions and FSM states for the MMIO UART TX
package svc_rv_uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CLKDIV = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_BUSY      = 2;
    localparam int ST_COUNT_LSB = 8;
    localparam int ST_OVF       = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_e;

endpackage

// File: rtl/svc_rv_mmio_uart_tx_if.sv
// rtl/svc_rv_mmio_uart_tx_if.sv - SoC MMIO io_* read/write bus between the core and an IO responder
interface svc_rv_mmio_uart_tx_if;
    logic [31:0] io_raddr;
    logic [31:0] io_rdata;
    logic        io_wen;
    logic [31:0] io_waddr;
    logic [31:0] io_wdata;
    logic [3:0]  io_wstrb;

    modport master (
        output io_raddr, io_wen, io_waddr, io_wdata, io_wstrb,
        input  io_rdata
    );

    modport slave (
        input  io_raddr, io_wen, io_waddr, io_wdata, io_wstrb,
        output io_rdata
    );
endinterface

// File: rtl/svc_sync_fifo.sv
// rtl/svc_sync_fifo.sv - single-clock FIFO with fall-through read data; push while full only lands with a pop
module svc_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: empty pointers hide stale entries.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/svc_rv_mmio_uart_tx.sv
// rtl/svc_rv_mmio_uart_tx.sv - MMIO UART transmitter: byte FIFO, status/divider registers, 8N1 serializer
module svc_rv_mmio_uart_tx
    import svc_rv_uart_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] CLKDIV_RST = 16'd867
) (
    input  logic                   clk,
    input  logic                   rst_n,
    svc_rv_mmio_uart_tx_if.slave   bus,
    output logic                   txd
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_e     state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    idx_q, idx_d;
    logic          txd_q, txd_d;
    logic [15:0]   clkdiv_q, clkdiv_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic [1:0]    wsel, rsel;
    logic          push_req, bit_end;
    logic [31:0]   status;
    logic          unused;

    assign wsel     = bus.io_waddr[3:2];
    assign rsel     = bus.io_raddr[3:2];
    assign push_req = bus.io_wen && (wsel == REG_DATA) && bus.io_wstrb[0];
    assign bit_end  = (cnt_q == '0);
    assign unused   = ^{bus.io_waddr[31:4], bus.io_waddr[1:0], bus.io_raddr[31:4],
                        bus.io_raddr[1:0], bus.io_wdata[31:17], bus.io_wstrb[3]};

    svc_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req),
        .wdata (bus.io_wdata[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        status                        = '0;
        status[ST_FULL]               = fifo_full;
        status[ST_EMPTY]              = fifo_empty;
        status[ST_BUSY]               = (state_q != S_IDLE) || !fifo_empty;
        status[ST_COUNT_LSB +: CW]    = fifo_count;
        status[ST_OVF]                = ovf_q;

        case (rsel)
            REG_STATUS: rdata_d = status;
            REG_CLKDIV: rdata_d = {16'h0, clkdiv_q};
            default:    rdata_d = '0;
        endcase

        ovf_d = ovf_q;
        if (push_req && fifo_full && !fifo_pop)
            ovf_d = 1'b1;
        else if (bus.io_wen && (wsel == REG_STATUS) && bus.io_wstrb[2] && bus.io_wdata[ST_OVF])
            ovf_d = 1'b0;

        clkdiv_d = clkdiv_q;
        if (bus.io_wen && (wsel == REG_CLKDIV)) begin
            if (bus.io_wstrb[0]) clkdiv_d[7:0]  = bus.io_wdata[7:0];
            if (bus.io_wstrb[1]) clkdiv_d[15:8] = bus.io_wdata[15:8];
        end
    end

    // Every bit boundary reloads the counter from CLKDIV, so divider writes apply on the next bit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        fifo_pop = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    cnt_d    = clkdiv_q;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = clkdiv_q;
                    idx_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d   = clkdiv_q;
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
                        cnt_d    = clkdiv_q;
                        state_d  = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            idx_q    <= '0;
            txd_q    <= 1'b1;
            clkdiv_q <= CLKDIV_RST;
            ovf_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            txd_q    <= txd_d;
            clkdiv_q <= clkdiv_d;
            ovf_q    <= ovf_d;
            rdata_q  <= rdata_d;
        end
    end

    assign txd          = txd_q;
    assign bus.io_rdata = rdata_q;

endmodule

// File: tb/tb_svc_rv_mmio_uart_tx.sv
// tb/tb_svc_rv_mmio_uart_tx.sv - directed vector bench for svc_rv_mmio_uart_tx
module tb_svc_rv_mmio_uart_tx;

    logic clk = 1'b0;
    logic rst_n;
    logic txd;

    svc_rv_mmio_uart_tx_if bus ();

    svc_rv_mmio_uart_tx #(.FIFO_DEPTH(8), .CLKDIV_RST(16'd867)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .txd   (txd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] raddr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t        tbl [15];
    int          nvec = 0;
    int          nfail = 0;
    logic [7:0]  wb [16];
    int          sb_n;
    int          sb_div;
    int          chk_c [4];
    logic [31:0] chk_v [4];
    int          nchk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bus.io_wen   = 1'b1;
        bus.io_waddr = addr;
        bus.io_wdata = data;
        bus.io_wstrb = strb;
        tick();
        bus.io_wen   = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
        bus.io_raddr = addr;
        tick();
        chk(name, bus.io_rdata, exp);
    endtask

    // Expected line level k cycles after the first start bit, for the sb_n queued bytes.
    function automatic logic exp_line(input int k);
        int bp, f, b;
        if (k < 0) return 1'b1;
        bp = sb_div + 1;
        f  = k / (10 * bp);
        if (f >= sb_n) return 1'b1;
        b = (k % (10 * bp)) / bp;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return wb[f][b-1];
    endfunction

    task automatic run(input int nwr, input int nemit, input int div, input int ncyc);
        sb_n   = nemit;
        sb_div = div;
        for (int c = 0; c < ncyc; c++) begin
            bus.io_raddr = 32'h4;
            if (c < nwr) begin
                bus.io_wen   = 1'b1;
                bus.io_waddr = 32'h0;
                bus.io_wdata = {24'h0, wb[c]};
                bus.io_wstrb = 4'b0001;
            end else begin
                bus.io_wen = 1'b0;
            end
            chk($sformatf("txd c%0d", c), {31'b0, txd}, {31'b0, exp_line(c - 2)});
            tick();
            for (int k = 0; k < nchk; k++)
                if (chk_c[k] == c) chk($sformatf("status c%0d", c), bus.io_rdata, chk_v[k]);
        end
        bus.io_wen = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 32'h0, 32'h0,         4'h0,    32'h4,         32'h0000_0002};
        tbl[1]  = '{1'b0, 32'h0, 32'h0,         4'h0,    32'h8,         32'd867};
        tbl[2]  = '{1'b0, 32'h0, 32'h0,         4'h0,    32'hC,         32'h0};
        tbl[3]  = '{1'b0, 32'h0, 32'h0,         4'h0,    32'h0,         32'h0};
        tbl[4]  = '{1'b1, 32'h8, 32'hFFFF_FF07, 4'b0001, 32'h8,         32'd867};
        tbl[5]  = '{1'b0, 32'h0, 32'h0,         4'h0,    32'h8,         32'h0000_0307};
        tbl[6]  = '{1'b1, 32'h8, 32'h0000_0500, 4'b0010, 32'h8,         32'h0000_0307};
        tbl[7]  = '{1'b0, 32'h0, 32'h0,         4'h0,    32'h8,         32'h0000_0507};
        tbl[8]  = '{1'b1, 32'hC, 32'hFFFF_FFFF, 4'hF,    32'hC,         32'h0};
        tbl[9]  = '{1'b0, 32'h0, 32'h0,         4'h0,    32'hC,         32'h0};
        tbl[10] = '{1'b1, 32'h0, 32'h0000_0055, 4'b0010, 32'h4,         32'h0000_0002};
        tbl[11] = '{1'b0, 32'h0, 32'h0,         4'h0,    32'h4,         32'h0000_0002};
        tbl[12] = '{1'b1, 32'h8, 32'hABCD_1234, 4'b0011, 32'h8,         32'h0000_0507};
        tbl[13] = '{1'b0, 32'h0, 32'h0,         4'h0,    32'h8,         32'h0000_1234};
        tbl[14] = '{1'b0, 32'h0, 32'h0,         4'h0,    32'hFFFF_FFF8, 32'h0000_1234};

        rst_n        = 1'b0;
        bus.io_wen   = 1'b0;
        bus.io_waddr = '0;
        bus.io_wdata = '0;
        bus.io_wstrb = '0;
        bus.io_raddr = 32'h4;
        tick();
        tick();
        chk("reset txd", {31'b0, txd}, 32'h1);
        chk("reset rdata", bus.io_rdata, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            bus.io_wen   = tbl[i].wen;
            bus.io_waddr = tbl[i].waddr;
            bus.io_wdata = tbl[i].wdata;
            bus.io_wstrb = tbl[i].wstrb;
            bus.io_raddr = tbl[i].raddr;
            tick();
            chk($sformatf("vec%0d rdata", i), bus.io_rdata, tbl[i].exp_rdata);
            chk($sformatf("vec%0d txd", i), {31'b0, txd}, 32'h1);
        end
        bus.io_wen = 1'b0;

        // Single 0xA5 frame at CLKDIV=3.
        wr(32'h8, 32'd3, 4'hF);
        wb[0] = 8'hA5;
        nchk = 4;
        chk_c[0] = 0;  chk_v[0] = 32'h0000_0002;
        chk_c[1] = 1;  chk_v[1] = 32'h0000_0104;
        chk_c[2] = 41; chk_v[2] = 32'h0000_0006;
        chk_c[3] = 42; chk_v[3] = 32'h0000_0002;
        run(1, 1, 3, 46);

        // Three back-to-back frames at CLKDIV=1.
        wr(32'h8, 32'd1, 4'hF);
        wb[0] = 8'h01; wb[1] = 8'h02; wb[2] = 8'h03;
        nchk = 4;
        chk_c[0] = 2;  chk_v[0] = 32'h0000_0104;
        chk_c[1] = 3;  chk_v[1] = 32'h0000_0204;
        chk_c[2] = 61; chk_v[2] = 32'h0000_0006;
        chk_c[3] = 62; chk_v[3] = 32'h0000_0002;
        run(3, 3, 1, 64);

        // Overrun: 12 writes, 9 accepted.
        for (int i = 0; i < 12; i++) wb[i] = 8'h10 + 8'(i);
        nchk = 3;
        chk_c[0] = 9;   chk_v[0] = 32'h0000_0805;
        chk_c[1] = 10;  chk_v[1] = 32'h0001_0805;
        chk_c[2] = 182; chk_v[2] = 32'h0001_0002;
        run(12, 9, 1, 184);
        wr(32'h4, 32'h0001_0000, 4'b0001);
        rd(32'h4, 32'h0001_0002, "ovf kept wrong strobe");
        wr(32'h4, 32'h0001_0000, 4'b0100);
        rd(32'h4, 32'h0000_0002, "ovf cleared");

        // Reset in the middle of a data bit discards the queued byte.
        wr(32'h8, 32'd3, 4'hF);
        wb[0] = 8'h00; wb[1] = 8'h33;
        nchk = 0;
        run(2, 1, 3, 9);
        chk("txd in data bit", {31'b0, txd}, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("txd async reset", {31'b0, txd}, 32'h1);
        chk("rdata async reset", bus.io_rdata, 32'h0);
        tick();
        rst_n = 1'b1;
        rd(32'h4, 32'h0000_0002, "status after reset");
        rd(32'h8, 32'd867, "clkdiv after reset");
        chk("txd after reset", {31'b0, txd}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
